fifo_port_arbiter: RTL and testbench

//  Shares one 2^DEPTH_LOG2-entry FIFO storage array between NREQ requesters.

---
 rtl/fifo_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter sharing one sync-read FIFO storage array among NREQ req/ack ports.
// Grant at cycle 0; nack at cycle 2, ack at cycle 3; one transaction per 4 cycles.
`timescale 1ns/1ps
module fifo_port_arbiter #(
  parameter int NREQ       = 2,
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        rw,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        nack,
  output logic [DATA_W-1:0]      rdata,
  output logic [DEPTH_LOG2-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   busy
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, ACCESS, RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last_grant;
  logic                r_rw;
  logic                r_refuse;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_rdata;
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;

  logic [ID_W-1:0]     w_pick_id;
  logic                w_pick_vld;
  logic [DEPTH_LOG2:0] w_sel_ptr;
  logic                w_full;
  logic                w_empty;
  logic                w_refuse_now;
  logic                w_read_ack;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    int idx;
    idx        = 0;
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_pick_vld && req[idx[ID_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = idx[ID_W-1:0];
      end
    end
  end

  assign w_full       = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                        (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_sel_ptr    = r_rw ? r_wr_ptr : r_rd_ptr;
  assign w_refuse_now = r_rw ? w_full : w_empty;
  assign w_read_ack   = (r_state == RESP) && !r_rw && !r_refuse;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_refuse_now ? RESP : ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
      r_rw         <= 1'b0;
      r_refuse     <= 1'b0;
      r_data       <= '0;
      r_rdata      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_id     <= w_pick_id;
            r_rw     <= rw[w_pick_id];
            r_data   <= wdata[w_pick_id*DATA_W +: DATA_W];
            r_refuse <= 1'b0;
          end
        end
        CHECK:  r_refuse <= w_refuse_now;
        ACCESS: begin
          if (r_rw) r_wr_ptr <= r_wr_ptr + PTR_ONE;
          else      r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        RESP: begin
          r_last_grant <= r_id;
          if (w_read_ack) r_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack  = '0;
    nack = '0;
    if (r_state == RESP) begin
      if (r_refuse) nack[r_id] = 1'b1;
      else          ack[r_id]  = 1'b1;
    end
  end

  // The memory address is held through ACCESS so the sync read lands in RESP.
  assign mem_addr  = ((r_state == CHECK) || (r_state == ACCESS)) ? w_sel_ptr[DEPTH_LOG2-1:0] : '0;
  assign mem_we    = (r_state == ACCESS) && r_rw;
  assign mem_wdata = mem_we ? r_data : '0;
  assign rdata     = w_read_ack ? mem_rdata : r_rdata;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: vector table, hand sequences, and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_fifo_port_arbiter;
  localparam int NREQ = 2, DL = 3, DW = 4, DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req, rw, ack, nack;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
  logic [DL-1:0]    mem_addr;
  logic             mem_we, full, empty, busy;
  logic [DL:0]      count;

  fifo_port_arbiter #(.NREQ(NREQ), .DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .wdata(wdata), .ack(ack), .nack(nack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .full(full), .empty(empty), .count(count), .busy(busy));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int checks = 0, failures = 0;

  logic [DW-1:0] mq[$];
  int            m_wtot;
  logic [DW-1:0] m_last;

  typedef struct {
    int       port;
    bit       wr;
    logic [3:0] d;
    bit       ok;
    logic [3:0] rd;
    int       addr;
    int       cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rw = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_nack", int'(nack), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    rst = 1'b0;
    mq.delete(); m_wtot = 0; m_last = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic run_txn(input int port, input bit wr, input logic [3:0] d, input bit exp_ok,
                         input logic [3:0] exp_rd, input int exp_addr, input int exp_cnt,
                         input string name);
    int c = 0, we_n = 0, we_c = -1, we_a = 0, we_d = 0;
    bit got = 1'b0;
    wait_idle();
    req[port] = 1'b1; rw[port] = wr; wdata[port*DW +: DW] = d;
    rw[1-port] = 1'($urandom_range(0, 1));
    wdata[(1-port)*DW +: DW] = 4'($urandom);
    @(posedge clk);
    while (!got && c < 10) begin
      @(negedge clk);
      c++;
      if (mem_we) begin we_n++; we_c = c; we_a = int'(mem_addr); we_d = int'(mem_wdata); end
      if ((ack | nack) != 0) got = 1'b1;
      else if (c == 1) begin
        rw[port] = ~wr;
        wdata[port*DW +: DW] = ~d;
        if ($urandom_range(0, 3) == 0) req[port] = 1'b0;
      end
    end
    chk({name, "_resp_seen"}, int'(got), 1);
    if (got) begin
      chk({name, "_latency"}, c, exp_ok ? 3 : 2);
      chk({name, "_ack"}, int'(ack), exp_ok ? (1 << port) : 0);
      chk({name, "_nack"}, int'(nack), exp_ok ? 0 : (1 << port));
      chk({name, "_rdata"}, int'(rdata), int'(exp_rd));
      chk({name, "_count"}, int'(count), exp_cnt);
      chk({name, "_full"}, int'(full), int'(exp_cnt == DEPTH));
      chk({name, "_empty"}, int'(empty), int'(exp_cnt == 0));
    end
    chk({name, "_we_pulses"}, we_n, int'(wr && exp_ok));
    if (wr && exp_ok && we_n == 1) begin
      chk({name, "_we_cycle"}, we_c, 2);
      chk({name, "_we_addr"}, we_a, exp_addr);
      chk({name, "_we_data"}, we_d, int'(d));
    end
    req[port] = 1'b0;
  endtask

  task automatic model_txn(input int port, input bit wr, input logic [3:0] d, input string name);
    bit ok;
    int addr;
    ok   = wr ? (mq.size() < DEPTH) : (mq.size() > 0);
    addr = m_wtot % DEPTH;
    if (ok && wr) begin mq.push_back(d); m_wtot++; end
    if (ok && !wr) m_last = mq.pop_front();
    run_txn(port, wr, d, ok, m_last, addr, mq.size(), name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b1, 4'hA, 1'b1, 4'h0, 0, 1};
    tbl[1] = '{1, 1'b0, 4'h0, 1'b1, 4'hA, 0, 0};
    tbl[2] = '{1, 1'b0, 4'h0, 1'b0, 4'hA, 0, 0};
    tbl[3] = '{0, 1'b1, 4'h3, 1'b1, 4'hA, 1, 1};
    tbl[4] = '{1, 1'b1, 4'h5, 1'b1, 4'hA, 2, 2};
    tbl[5] = '{0, 1'b0, 4'h0, 1'b1, 4'h3, 0, 1};
    tbl[6] = '{1, 1'b0, 4'h0, 1'b1, 4'h5, 0, 0};
    tbl[7] = '{0, 1'b0, 4'h0, 1'b0, 4'h5, 0, 0};

    do_reset();
    run_txn(1, 1'b0, 4'h0, 1'b0, 4'h0, 0, 0, "empty_read");
    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].port, tbl[i].wr, tbl[i].d, tbl[i].ok, tbl[i].rd, tbl[i].addr, tbl[i].cnt,
              $sformatf("vec%0d", i));

    // Fill, overfill, drain, then wrap the write pointer.
    do_reset();
    for (int i = 0; i < 8; i++) model_txn(i % 2, 1'b1, 4'(i), $sformatf("fill%0d", i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    model_txn(0, 1'b1, 4'h9, "overfull");
    for (int i = 0; i < 8; i++) model_txn(i % 2, 1'b0, 4'h0, $sformatf("drain%0d", i));
    chk("drain_empty", int'(empty), 1);
    for (int i = 0; i < 4; i++) model_txn(0, 1'b1, 4'(8 + i), $sformatf("wrap%0d", i));
    chk("wrap_count", int'(count), 4);

    // Both ports hold write requests: grants must alternate 0,1,0,1 four cycles apart.
    do_reset();
    begin
      int k = 0, cyc = 0, prev = 0;
      wait_idle();
      req = 2'b11; rw = 2'b11; wdata = {4'd2, 4'd1};
      while (k < 4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (nack != 0) chk("rr_nack", int'(nack), 0);
        if (ack != 0) begin
          chk($sformatf("rr_port%0d", k), int'(ack), 1 << (k % 2));
          chk($sformatf("rr_gap%0d", k), cyc - prev, (k == 0) ? 3 : 4);
          prev = cyc;
          if (ack[0]) wdata[3:0] = 4'd3;
          if (ack[1]) wdata[7:4] = 4'd4;
          k++;
        end
      end
      chk("rr_acks", k, 4);
      req = '0;
      for (int i = 1; i <= 4; i++) begin mq.push_back(4'(i)); m_wtot++; end
      for (int i = 0; i < 4; i++) model_txn(i % 2, 1'b0, 4'h0, $sformatf("rr_read%0d", i));
    end

    // Reset landing in the ACCESS cycle of a write.
    do_reset();
    begin
      int n = 0, seen = 0;
      wait_idle();
      req[0] = 1'b1; rw[0] = 1'b1; wdata[3:0] = 4'h7;
      while (!mem_we && n < 10) begin @(negedge clk); n++; end
      chk("mid_we_seen", int'(mem_we), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_we_drop", int'(mem_we), 0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_count", int'(count), 0);
      chk("mid_empty", int'(empty), 1);
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      mq.delete(); m_wtot = 0; m_last = '0;
      repeat (6) begin
        @(negedge clk);
        if ((ack | nack) != 0) seen++;
      end
      chk("mid_no_resp", seen, 0);
      model_txn(1, 1'b1, 4'hC, "post_rst_wr");
      model_txn(0, 1'b0, 4'h0, "post_rst_rd");
    end

    do_reset();
    for (int i = 0; i < 150; i++)
      model_txn(int'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55), 4'($urandom),
                $sformatf("rnd%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
